// File: rtl/regfile_pkg.sv
// Shared defaults and port-slicing helpers for the register file slice.
// Packed multi-port buses place port p at [p*W +: W].
`ifndef REGFILE_PKG_SV
`define REGFILE_PKG_SV
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int ZERO_REG   = 0;
endpackage
`endif

// File: rtl/regfile_bypass_mux.sv
// Per-read-port bypass selection between the two write ports and storage.
// Port 1 outranks port 0; hit drives the rbusy mask in the top.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]   raddr,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] waddr,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]   stored,
  output logic [DATA_W-1:0]   rdata,
  output logic                hit
);

  logic nz;
  logic hit0;
  logic hit1;

  assign nz   = raddr != ADDR_W'(ZERO_REG);
  assign hit1 = nz && we[1]
             && (`RF_SLICE(waddr, 1, ADDR_W) == raddr);
  assign hit0 = nz && we[0] && !hit1
             && (`RF_SLICE(waddr, 0, ADDR_W) == raddr);
  assign hit  = hit0 | hit1;

  always_comb begin
    rdata = stored;
    unique case (1'b1)
      hit1:    rdata = `RF_SLICE(wdata, 1, DATA_W);
      hit0:    rdata = `RF_SLICE(wdata, 0, DATA_W);
      default: rdata = stored;
    endcase
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass and a pending-write
// scoreboard; register 0 reads as zero and is never busy.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               we,
  input  logic [2*ADDR_W-1:0]      waddr,
  input  logic [2*DATA_W-1:0]      wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [ADDR_W-1:0]        debug_addr,
  output logic [DATA_W-1:0]        debug_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic [ADDR_W-1:0] wa0;
  logic [ADDR_W-1:0] wa1;
  logic              wr0;
  logic              wr1;

  assign wa0 = `RF_SLICE(waddr, 0, ADDR_W);
  assign wa1 = `RF_SLICE(waddr, 1, ADDR_W);
  assign wr0 = we[0] && (wa0 != ZA);
  assign wr1 = we[1] && (wa1 != ZA);

  // Issue is applied after clears so a newer producer stays pending.
  always_comb begin
    busy_nxt = busy;
    if (wr0) busy_nxt[wa0] = 1'b0;
    if (wr1) busy_nxt[wa1] = 1'b0;
    if (issue_en && (issue_addr != ZA))
      busy_nxt[issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++)
        regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr0) regs[wa0] <= `RF_SLICE(wdata, 0, DATA_W);
      if (wr1) regs[wa1] <= `RF_SLICE(wdata, 1, DATA_W);
      busy <= busy_nxt;
    end
  end

  assign debug_data = (debug_addr == ZA) ? '0
                                         : regs[debug_addr];

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;
    logic              hit;

    assign ra     = `RF_SLICE(raddr, r, ADDR_W);
    assign stored = (ra == ZA) ? '0 : regs[ra];

    regfile_bypass_mux #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_mux (
      .raddr (ra),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .stored(stored),
      .rdata (`RF_SLICE(rdata, r, DATA_W)),
      .hit   (hit)
    );

    assign rbusy[r] = busy[ra] & ~hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, async reset sequence,
// then random traffic checked against an array-based reference model.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [1:0]  we;
  logic [4:0]  wa0, wa1, ra0, ra1;
  logic [31:0] wd0, wd1;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [4:0]  debug_addr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [31:0] debug_data;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     ({wa1, wa0}),
    .wdata     ({wd1, wd0}),
    .raddr     ({ra1, ra0}),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .debug_addr(debug_addr),
    .debug_data(debug_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  da;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_bz;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t tbl [15];

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mregs [32];
  bit          mbusy [32];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  function automatic bit m_wr(logic [4:0] a);
    return (a != 0) &&
           ((we[0] && wa0 == a) || (we[1] && wa1 == a));
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0) return '0;
    if (we[1] && wa1 == a) return wd1;
    if (we[0] && wa0 == a) return wd0;
    return mregs[a];
  endfunction

  function automatic logic m_busy(logic [4:0] a);
    return (a != 0) && mbusy[a] && !m_wr(a);
  endfunction

  // Called just after a posedge while inputs are still held.
  task automatic model_edge();
    if (rst) return;
    if (we[0] && wa0 != 0) begin
      mregs[wa0] = wd0;
      mbusy[wa0] = 1'b0;
    end
    if (we[1] && wa1 != 0) begin
      mregs[wa1] = wd1;
      mbusy[wa1] = 1'b0;
    end
    if (issue_en && issue_addr != 0) mbusy[issue_addr] = 1'b1;
  endtask

  task automatic drive(vec_t v);
    we = v.we; wa0 = v.wa0; wa1 = v.wa1;
    wd0 = v.wd0; wd1 = v.wd1;
    ra0 = v.ra0; ra1 = v.ra1;
    issue_en = v.ie; issue_addr = v.ia;
    debug_addr = v.da;
  endtask

  task automatic idle();
    we = 2'b00; issue_en = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 4) == 0) return 5'd0;
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(1, 4));
    return 5'($urandom_range(1, 31));
  endfunction

  initial begin
    vec_t z;
    z = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0,
          1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 32'd0};

    tbl[0]  = '{2'b01, 5'd5, 5'd0, 32'h1234_5678, 32'd0, 5'd5, 5'd0,
                1'b0, 5'd0, 5'd5,
                32'h1234_5678, 32'd0, 2'b00, 32'd0};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5,
                1'b0, 5'd0, 5'd5,
                32'h1234_5678, 32'h1234_5678, 2'b00, 32'h1234_5678};
    tbl[2]  = '{2'b11, 5'd7, 5'd7, 32'hAAAA_AAAA, 32'h5555_5555,
                5'd7, 5'd5, 1'b0, 5'd0, 5'd7,
                32'h5555_5555, 32'h1234_5678, 2'b00, 32'd0};
    tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7,
                1'b0, 5'd0, 5'd7,
                32'h5555_5555, 32'h5555_5555, 2'b00, 32'h5555_5555};
    tbl[4]  = '{2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                5'd0, 5'd0, 1'b1, 5'd0, 5'd0,
                32'd0, 32'd0, 2'b00, 32'd0};
    tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0,
                1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 32'd0};
    tbl[6]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3,
                1'b1, 5'd3, 5'd3, 32'd0, 32'd0, 2'b00, 32'd0};
    tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd0,
                1'b0, 5'd0, 5'd3, 32'd0, 32'd0, 2'b01, 32'd0};
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = '{2'b01, 5'd3, 5'd0, 32'hCAFE_0003, 32'd0, 5'd3, 5'd3,
                1'b1, 5'd3, 5'd3,
                32'hCAFE_0003, 32'hCAFE_0003, 2'b00, 32'd0};
    tbl[11] = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3,
                1'b0, 5'd0, 5'd3,
                32'hCAFE_0003, 32'hCAFE_0003, 2'b11, 32'hCAFE_0003};
    tbl[12] = '{2'b10, 5'd0, 5'd3, 32'd0, 32'h0BAD_0003, 5'd3, 5'd7,
                1'b0, 5'd0, 5'd3,
                32'h0BAD_0003, 32'h5555_5555, 2'b00, 32'hCAFE_0003};
    tbl[13] = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd7,
                1'b0, 5'd0, 5'd3,
                32'h0BAD_0003, 32'h5555_5555, 2'b00, 32'h0BAD_0003};
    tbl[14] = '{2'b11, 5'd9, 5'd10, 32'h0000_0099, 32'h0000_1010,
                5'd9, 5'd10, 1'b0, 5'd0, 5'd9,
                32'h0000_0099, 32'h0000_1010, 2'b00, 32'd0};

    drive(z);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state across every address.
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(31 - a); debug_addr = 5'(a);
      #1;
      chk("rst_rd0", rdata[31:0], 32'd0);
      chk("rst_rd1", rdata[63:32], 32'd0);
      chk("rst_bz", {30'd0, rbusy}, 32'd0);
      chk("rst_dbg", debug_data, 32'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d_rd0", i), rdata[31:0], tbl[i].e_rd0);
      chk($sformatf("v%0d_rd1", i), rdata[63:32], tbl[i].e_rd1);
      chk($sformatf("v%0d_bz", i), {30'd0, rbusy},
          {30'd0, tbl[i].e_bz});
      chk($sformatf("v%0d_dbg", i), debug_data, tbl[i].e_dbg);
      @(posedge clk);
      model_edge();
      #1;
    end

    // Async reset with r9 busy and holding data.
    drive(z);
    we = 2'b01; wa0 = 5'd9; wd0 = 32'hDEAD_BEEF;
    @(posedge clk); model_edge(); #1;
    idle();
    issue_en = 1'b1; issue_addr = 5'd9;
    @(posedge clk); model_edge(); #1;
    idle();
    ra0 = 5'd9; ra1 = 5'd9; debug_addr = 5'd9;
    #1;
    chk("ar_pre_rd", rdata[31:0], 32'hDEAD_BEEF);
    chk("ar_pre_bz", {31'd0, rbusy[0]}, 32'd1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("ar_rd", rdata[31:0], 32'd0);
    chk("ar_bz", {30'd0, rbusy}, 32'd0);
    chk("ar_dbg", debug_data, 32'd0);
    we = 2'b01; wa0 = 5'd9; wd0 = 32'h0000_0011;
    issue_en = 1'b1; issue_addr = 5'd9;
    @(posedge clk); model_edge(); #1;
    idle();
    #1;
    chk("ar_drop_rd", rdata[31:0], 32'd0);
    chk("ar_drop_bz", {30'd0, rbusy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); model_edge(); #1;
    chk("ar_post_dbg", debug_data, 32'd0);
    chk("ar_post_bz", {30'd0, rbusy}, 32'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      we = 2'($urandom_range(0, 3));
      wa0 = pick(); wa1 = pick();
      wd0 = $urandom; wd1 = $urandom;
      ra0 = pick(); ra1 = pick();
      issue_en = ($urandom_range(0, 2) == 0);
      issue_addr = pick();
      debug_addr = pick();
      @(negedge clk);
      chk("rnd_rd0", rdata[31:0], m_read(ra0));
      chk("rnd_rd1", rdata[63:32], m_read(ra1));
      chk("rnd_bz", {30'd0, rbusy},
          {30'd0, m_busy(ra1), m_busy(ra0)});
      chk("rnd_dbg", debug_data,
          (debug_addr == 0) ? 32'd0 : mregs[debug_addr]);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general-purpose register file with a per-register busy scoreboard, the next-generation regfile for the pipelined CPU datapath. It provides NUM_RD combinational read ports, two prioritised write ports with same-cycle write-to-read bypass, and a hardwired-zero register 0. It also provides a pending-write scoreboard that decode uses for hazard detection, plus a debug read port for the board display.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W, register 0 hardwired to zero
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- we  in  2  write enables, bit p = write port p
- waddr  in  2*ADDR_W  write addresses, port p at [p*ADDR_W +: ADDR_W]
- wdata  in  2*DATA_W  write data, port p at [p*DATA_W +: DATA_W]
- raddr  in  NUM_RD*ADDR_W  read addresses, packed as for waddr
- rdata  out  NUM_RD*DATA_W  read data, combinational
- rbusy  out  NUM_RD  busy flag of each read address, combinational
- issue_en  in  1  mark issue_addr as having a pending write
- issue_addr  in  ADDR_W  destination register being issued
- debug_addr  in  ADDR_W  debug read address
- debug_data  out  DATA_W  debug read data (stored value, no bypass)

## Operation
- Storage: regs[1..2**ADDR_W-1]. Register 0 is not stored. Any read of address 0 returns 0 and rbusy 0.
- Write: at posedge, port p writes wdata_p into regs[waddr_p] when we[p]=1 and waddr_p≠0.
- Write collision: if both ports write the same nonzero address in the same cycle, port 1 wins.
- Read port r:
  - If a write enable targets raddr_r (nonzero) this cycle, rdata_r = that write's wdata (bypass), with port 1 taking priority over port 0.
  - Otherwise rdata_r = regs[raddr_r].
- Scoreboard: busy[1..] bits.
  - Issue: issue_en=1 with issue_addr≠0 sets busy[issue_addr] at posedge.
  - Write: any write to address a clears busy[a] at posedge.
  - Simultaneous issue and write to the same address: set wins, because the newer producer is outstanding.
  - issue_en with issue_addr=0 is ignored.
- rbusy_r = busy[raddr_r] AND NOT (a write to raddr_r is active this cycle). This is consistent with the bypassed rdata. A same-cycle issue does not affect rbusy until the next cycle.
- debug_data = regs[debug_addr], or 0 for address 0. It reflects state after the last edge.

## Timing
- Reset value of all regs and all busy bits: 0.
- Reset values of outputs: rdata = 0, rbusy = 0, debug_data = 0 (all combinational from cleared state).
- rst asserted mid-operation clears everything immediately, overriding any same-edge write or issue. Writes and issues resume on the first posedge after rst deasserts.
- Read latency: 0 cycles (combinational). Write latency: visible through regs from the cycle after the posedge, and through bypass within the same cycle.
- Scoreboard latency: the issue edge sets busy, rbusy is high from the next cycle, and the writeback cycle shows rbusy=0.
- No handshake; inputs must be stable before posedge.

## Structure
- Shared package/header regfile_pkg: DATA_W/ADDR_W defaults, ZERO_REG localparam, port-slicing macros.
- One natural sub-module: regfile_bypass_mux, per read port. It takes raddr plus both write ports and the stored value, and produces rdata and a bypass-hit flag that rbusy reuses. It is instantiated NUM_RD times via generate.
- Scoreboard and storage live in the top module. Writes are on posedge clk only.

## Test plan
- Reset then read all addresses: rdata=0, rbusy=0, debug_data=0 everywhere.
- Write port0 r5=0x1234_5678, reading r5 the same cycle: rdata=0x1234_5678 via bypass. The next cycle the stored value and debug_data(5) are 0x1234_5678.
- Both ports write r7 (port0 0xAAAA_AAAA, port1 0x5555_5555): rdata=0x5555_5555 the same cycle and after.
- Write 0xFFFF_FFFF to r0 and issue r0: rdata(0)=0, rbusy(0)=0 always.
- Issue r3, then 3 idle cycles: rbusy(r3)=1 each cycle. Writeback r3 with a concurrent issue of r3: rbusy=0 that cycle and 1 the next. Writeback again alone: 0 thereafter.
- Assert rst asynchronously between edges with r9 busy and nonzero: r9 becomes 0 and busy clears immediately. A write presented at the edge during rst is dropped.
